// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter that shares one fixed-latency data-memory port between the
// CPU (port 0) and an external loader/debug requester (port 1).
module dmem_port_arbiter #(
  parameter int MEM_LAT = 1,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req0_i,
  input  logic              req1_i,
  input  logic              we0_i,
  input  logic              we1_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic              ack0_o,
  output logic              ack1_o,
  output logic [DATA_W-1:0] rdata0_o,
  output logic [DATA_W-1:0] rdata1_o,
  output logic              cpu_stall_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              busy_o,
  output logic              owner_o
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  localparam logic [3:0] LAT_CNT = 4'(MEM_LAT);

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  // The owner register doubles as last_grant: it always holds the most recent winner.
  logic                owner_q, owner_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q [0:1];
  logic [DATA_W-1:0]   rdata_d [0:1];
  logic                grant_valid;
  logic                grant_port;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    grant_valid = req0_i | req1_i;
    grant_port  = owner_q;

    case (state_q)
      S_IDLE: begin
        if (req0_i && req1_i) begin
          grant_port = ~owner_q;
        end else begin
          grant_port = req1_i;
        end
        if (grant_valid) begin
          owner_d = grant_port;
          we_d    = grant_port ? we1_i    : we0_i;
          addr_d  = grant_port ? addr1_i  : addr0_i;
          wdata_d = grant_port ? wdata1_i : wdata0_i;
          cnt_d   = LAT_CNT;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          // Memory data is only guaranteed valid in the final BUSY cycle.
          if (!we_q) begin
            rdata_d[owner_q] = mem_rdata_i;
          end
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      owner_q    <= 1'b1;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q[0] <= '0;
      rdata_q[1] <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q[0] <= rdata_d[0];
      rdata_q[1] <= rdata_d[1];
    end
  end

  // Writes strobe only in the last BUSY cycle so an aborted write never lands.
  assign mem_read_o  = (state_q == S_BUSY) && !we_q;
  assign mem_write_o = (state_q == S_BUSY) && we_q && (cnt_q == 4'd1);
  assign ack0_o      = (state_q == S_DONE) && !owner_q;
  assign ack1_o      = (state_q == S_DONE) && owner_q;
  assign busy_o      = (state_q != S_IDLE);
  assign owner_o     = owner_q;
  assign cpu_stall_o = req0_i && !ack0_o;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign rdata0_o    = rdata_q[0];
  assign rdata1_o    = rdata_q[1];

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed scenarios plus random traffic, checked every
// cycle against a transaction-timestamp model of the arbiter and a reference memory.
module tb_dmem_port_arbiter;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        ack0, ack1, stall, mem_read, mem_write, busy, owner;
  logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  dmem_port_arbiter #(.MEM_LAT(LAT), .ADDR_W(32), .DATA_W(32)) dut (
    .clk_i(clk), .rst_i(rst),
    .req0_i(req0), .req1_i(req1), .we0_i(we0), .we1_i(we1),
    .addr0_i(addr0), .addr1_i(addr1), .wdata0_i(wdata0), .wdata1_i(wdata1),
    .ack0_o(ack0), .ack1_o(ack1), .rdata0_o(rdata0), .rdata1_o(rdata1),
    .cpu_stall_o(stall), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_read_o(mem_read), .mem_write_o(mem_write), .mem_rdata_i(mem_rdata),
    .busy_o(busy), .owner_o(owner)
  );

  // Environment memory seen by the DUT.
  logic [31:0] env_mem [0:63];
  assign mem_rdata = env_mem[mem_addr[7:2]];
  always @(posedge clk) if (mem_write) env_mem[mem_addr[7:2]] <= mem_wdata;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
    end
  endtask

  // Model: one in-flight transaction described by its grant cycle m_t0.
  bit          m_active = 1'b0;
  int          m_t0 = 0;
  bit          m_port = 1'b0;
  bit          m_we = 1'b0;
  logic [31:0] m_addr = 32'd0;
  logic [31:0] m_wdata = 32'd0;
  bit          m_owner = 1'b1;
  logic [31:0] m_rdata [0:1];
  logic [31:0] ref_mem [0:63];

  always @(negedge clk) begin : compare
    int c;
    bit inb, ind, e_ack0, e_ack1, fin;
    if (cyc > 0) begin
      c = cyc;
      if (m_active && c >= m_t0 + LAT + 2) m_active = 1'b0;
      inb    = m_active && (c > m_t0) && (c <= m_t0 + LAT);
      ind    = m_active && (c == m_t0 + LAT + 1);
      fin    = inb && (c == m_t0 + LAT);
      e_ack0 = ind && !m_port;
      e_ack1 = ind && m_port;
      chk("ack0", ack0, e_ack0);
      chk("ack1", ack1, e_ack1);
      chk("busy", busy, inb || ind);
      chk("owner", owner, m_owner);
      chk("mem_read", mem_read, inb && !m_we);
      chk("mem_write", mem_write, fin && m_we);
      chk("cpu_stall", stall, req0 && !e_ack0);
      chk("rdata0", rdata0, m_rdata[0]);
      chk("rdata1", rdata1, m_rdata[1]);
      if (inb) chk("mem_addr", mem_addr, m_addr);
      if (inb && m_we) chk("mem_wdata", mem_wdata, m_wdata);
      if (fin) begin
        if (m_we) ref_mem[m_addr[7:2]] = m_wdata;
        else      m_rdata[m_port] = ref_mem[m_addr[7:2]];
      end
      if (rst) begin
        m_active = 1'b0; m_owner = 1'b1; m_addr = 32'd0; m_wdata = 32'd0;
        m_rdata[0] = 32'd0; m_rdata[1] = 32'd0;
      end else if (!m_active && (req0 || req1)) begin
        m_port   = (req0 && req1) ? !m_owner : req1;
        m_owner  = m_port;
        m_active = 1'b1;
        m_t0     = c;
        m_we     = m_port ? we1 : we0;
        m_addr   = m_port ? addr1 : addr0;
        m_wdata  = m_port ? wdata1 : wdata0;
      end
    end
  end

  task automatic set_ops(input bit p);
    logic [31:0] a;
    a = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
    if (p) begin we1 = 1'($urandom); addr1 = a; wdata1 = $urandom; end
    else   begin we0 = 1'($urandom); addr0 = a; wdata0 = $urandom; end
  endtask

  // Single access from one port; returns latency to ack and strobe/stall counts.
  task automatic access(input bit p, input bit we, input logic [31:0] a, input logic [31:0] d,
                        output int lat, output int nrd, output int nwr, output int nst);
    int t0;
    lat = -1; nrd = 0; nwr = 0; nst = 0;
    if (p) begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
    else   begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
    t0 = cyc;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mem_read) nrd++;
      if (mem_write) nwr++;
      if (stall) nst++;
      if (p ? ack1 : ack0) begin lat = cyc - t0; break; end
    end
    @(posedge clk); #1;
    if (p) req1 = 1'b0; else req0 = 1'b0;
  endtask

  task automatic wait_any_ack(output int port, output int at_cyc);
    port = -1; at_cyc = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ack0 || ack1) begin
        port = (ack0 && ack1) ? 2 : (ack1 ? 1 : 0);
        at_cyc = cyc;
        break;
      end
    end
  endtask

  initial begin : stim
    int lat, nrd, nwr, nst, p, at, r, t0;
    int exp_ofs [0:3];
    bit a0, a1;
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = 32'd0; addr1 = 32'd0; wdata0 = 32'd0; wdata1 = 32'd0;
    m_rdata[0] = 32'd0; m_rdata[1] = 32'd0;
    for (int i = 0; i < 64; i++) begin
      env_mem[i] = 32'hA500_0000 + i * 32'h0001_0203;
      ref_mem[i] = env_mem[i];
    end
    env_mem[4] = 32'hDEADBEEF; ref_mem[4] = 32'hDEADBEEF;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_owner", owner, 1'b1);
    chk("reset_busy", busy, 1'b0);
    chk("reset_rdata0", rdata0, 32'd0);
    chk("reset_mem_addr", mem_addr, 32'd0);
    rst = 1'b0;

    // Single CPU read
    access(1'b0, 1'b0, 32'h10, 32'd0, lat, nrd, nwr, nst);
    chk("t1_ack_latency", lat, 4);
    chk("t1_read_cycles", nrd, 3);
    chk("t1_stall_cycles", nst, 4);
    chk("t1_rdata0", rdata0, 32'hDEADBEEF);

    // Loader write then CPU read-back
    access(1'b1, 1'b1, 32'h20, 32'h12345678, lat, nrd, nwr, nst);
    chk("t2_write_cycles", nwr, 1);
    chk("t2_write_latency", lat, 4);
    access(1'b0, 1'b0, 32'h20, 32'd0, lat, nrd, nwr, nst);
    chk("t2_readback", rdata0, 32'h12345678);
    chk("t2_rdata1_untouched", rdata1, 32'd0);

    // Operand change during access
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
    @(posedge clk); #1;
    @(posedge clk); #1;
    addr0 = 32'h44;
    wait_any_ack(p, at);
    chk("t4_ack_port", p, 0);
    chk("t4_addr_held", mem_addr, 32'h10);
    chk("t4_rdata0", rdata0, 32'hDEADBEEF);
    @(posedge clk); #1;
    req0 = 1'b0;

    // Reset in the second BUSY cycle of a port-1 write
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'h30; wdata1 = 32'hCAFEF00D;
    nwr = 0; nst = 0;
    t0 = cyc;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (mem_write) nwr++;
      if (ack1) nst++;
      @(posedge clk); #1;
      if (cyc == t0 + 2) rst = 1'b1;
    end
    rst = 1'b0; req1 = 1'b0;
    chk("t5_busy_after_rst", busy, 1'b0);
    chk("t5_owner_after_rst", owner, 1'b1);
    chk("t5_rdata0_after_rst", rdata0, 32'd0);
    chk("t5_addr_after_rst", mem_addr, 32'd0);
    chk("t5_mem_intact", env_mem[12], 32'hA50C1824);
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h08;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h0C;
    wait_any_ack(p, at);
    chk("t5_no_write_pulse", nwr, 0);
    chk("t5_no_ack1", nst, 0);
    chk("t5_first_tie_port", p, 0);

    // Simultaneous requests held continuously from reset
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    r = cyc;
    exp_ofs[0] = 4; exp_ofs[1] = 9; exp_ofs[2] = 14; exp_ofs[3] = 19;
    for (int k = 0; k < 4; k++) begin
      wait_any_ack(p, at);
      chk("t3_grant_port", p, k % 2);
      chk("t3_ack_cycle", at - r, exp_ofs[k]);
    end

    // Random traffic with occasional resets
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      a0 = ack0; a1 = ack1;
      @(posedge clk); #1;
      rst = ($urandom_range(0, 99) == 0);
      if (req0 && a0) begin
        req0 = ($urandom_range(0, 3) != 0);
        if (req0) set_ops(1'b0);
      end else if (!req0 && $urandom_range(0, 2) == 0) begin
        req0 = 1'b1; set_ops(1'b0);
      end
      if (req1 && a1) begin
        req1 = ($urandom_range(0, 1) != 0);
        if (req1) set_ops(1'b1);
      end else if (!req1 && $urandom_range(0, 3) == 0) begin
        req1 = 1'b1; set_ops(1'b1);
      end
    end
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Two-port arbiter and sequencer that shares the single-cycle CPU's one data-memory port between the CPU load/store path (port 0) and an external requester such as a program/data loader or debug unit (port 1). It arbitrates round-robin and holds the chosen request stable against a memory with a fixed, parameterised access latency. It returns read data and a one-cycle acknowledge to the winner, and drives a stall signal that freezes the CPU program counter while a CPU access is outstanding.

## Interface
- MEM_LAT, 1: memory access latency in cycles, legal range 1..15.
- ADDR_W, 32: address width.
- DATA_W, 32: data width.
- clk_i  in  1  single clock, all state on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- req0_i / req1_i  in  1  access request from port 0 (CPU) / port 1 (loader).
- we0_i / we1_i  in  1  1 = write, 0 = read.
- addr0_i / addr1_i  in  ADDR_W  byte address.
- wdata0_i / wdata1_i  in  DATA_W  write data.
- ack0_o / ack1_o  out  1  one-cycle completion pulse.
- rdata0_o / rdata1_o  out  DATA_W  registered read result, per port.
- cpu_stall_o  out  1  req0_i & ~ack0_o (combinational); freezes the PC.
- mem_addr_o  out  ADDR_W  address to the data memory.
- mem_wdata_o  out  DATA_W  write data to the data memory.
- mem_read_o  out  1  read strobe (Mem_read).
- mem_write_o  out  1  write strobe (Mem_write).
- mem_rdata_i  in  DATA_W  memory read data, valid in the last BUSY cycle.
- busy_o  out  1  high in BUSY and DONE.
- owner_o  out  1  port currently granted; holds the last grant when idle.

## Operation
- FSM states: IDLE, BUSY, DONE. Per-port requests are sampled only in IDLE.
- **IDLE**
  - If no request is high, stay in IDLE.
  - If exactly one request is high, grant it.
  - If both are high, grant the port that is not last_grant.
  - On a grant: latch we/addr/wdata of the winner into internal registers, set owner_o and last_grant, load cnt = MEM_LAT, go to BUSY.
- **BUSY**
  - mem_addr_o and mem_wdata_o are driven from the latched registers and do not change even if the requester's inputs change.
  - Read: mem_read_o = 1 for every BUSY cycle.
  - Write: mem_write_o = 1 only in the final BUSY cycle (cnt == 1), so exactly one write edge occurs.
  - cnt decrements each cycle. On the cnt == 1 cycle, a read captures mem_rdata_i into rdataN_o of the owner, then the FSM goes to DONE.
- **DONE**
  - ackN_o = 1 for the owner for exactly this cycle. Memory strobes are 0. Go to IDLE.
- **Requester rule:** hold reqN and its operands stable until ackN is seen. In the cycle after ack, present req = 0 or a new request. A req still high in IDLE is treated as a new request.
- **Read data:** rdataN_o holds its value until the next read completion on the same port. Writes do not modify rdataN_o.
- **Fairness:** the non-owner's request is never dropped. With both ports requesting continuously, grants strictly alternate.

## Timing
- **Reset values:** state = IDLE; ack0_o = ack1_o = 0; mem_read_o = mem_write_o = 0; busy_o = 0; owner_o = 1; last_grant = 1, so port 0 wins the first tie; rdata0_o = rdata1_o = 0; mem_addr_o = mem_wdata_o = 0; cnt = 0.
- **Latency:** a request granted in IDLE cycle t occupies BUSY in cycles t+1 .. t+MEM_LAT. ack is asserted in cycle t+MEM_LAT+1. The earliest next grant is in cycle t+MEM_LAT+2.
- **Throughput:** one access per MEM_LAT+2 cycles.
- **cpu_stall_o:** high from the cycle req0_i rises through the cycle before ack0_o; low in the ack cycle.
- **Reset mid-operation:** at the reset edge, the FSM returns to IDLE and all strobes drop. No ack is issued for the aborted access. A write whose final BUSY cycle has not yet been reached is never performed.
- **Simultaneous events:** a new request arriving in BUSY or DONE waits; it is evaluated in the next IDLE cycle.

## Test plan
- **Single CPU read:** MEM_LAT=2, memory word 0x10 = 0xDEADBEEF, req0 read at addr 0x10 in cycle 0. Required: mem_read_o high in cycles 1–2, ack0_o in cycle 3, rdata0_o = 0xDEADBEEF, cpu_stall_o high in cycles 0–2.
- **Loader write then CPU read-back:** port 1 writes 0x12345678 to 0x20, then port 0 reads 0x20. Required: exactly one mem_write_o cycle (the last BUSY cycle), then rdata0_o = 0x12345678.
- **Simultaneous requests from reset:** both ports hold req high continuously. Required: grant order 0,1,0,1; acks in cycles MEM_LAT+1, 2·MEM_LAT+3, and so on; never two acks in the same cycle.
- **Operand change during access:** change addr0_i to 0x44 in mid-BUSY. Required: mem_addr_o stays at the latched 0x10 until DONE.
- **Reset mid-write:** MEM_LAT=4, assert rst_i in the second BUSY cycle of a port-1 write. Required: no mem_write_o pulse, no ack1_o, all outputs at reset values at the next edge, and port 0 wins the first tie afterwards.
